// File: rtl/move_sequencer_2048.sv
// move_sequencer_2048: game-level controller for the 2048 board.
// Synchronises the four active-low buttons, issues one slide/merge command
// per press, places a random 2/4 tile after each changing move and samples
// the win/over flags from the datapath.
module move_sequencer_2048 #(
  parameter logic [10:0] LFSR_SEED    = 11'h5A5,
  parameter int unsigned MOVE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        move_done,
  input  logic        board_changed,
  input  logic [15:0] empty_mask,
  input  logic        check_win,
  input  logic        check_over,
  output logic        move_start,
  output logic [1:0]  move_dir,
  output logic        spawn_valid,
  output logic [3:0]  spawn_idx,
  output logic [11:0] spawn_val,
  output logic        busy,
  output logic [1:0]  game_state
);

  localparam int unsigned TW = $clog2(MOVE_TIMEOUT);

  typedef enum logic [3:0] {
    S_INIT0, S_INIT1, S_IDLE, S_ISSUE, S_WAIT,
    S_SPAWN, S_SETTLE, S_CHECK, S_WON, S_LOST
  } state_t;

  state_t        state, state_nx;
  logic [10:0]   lfsr;
  logic [3:0]    sync1, sync2;     // {up, down, left, right}
  logic          armed;
  logic          accept;
  logic [1:0]    press_dir;
  logic [3:0]    scan_idx;
  logic [3:0]    scan_cnt;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          init_phase;
  logic          hit;

  assign accept    = (state == S_IDLE) && armed && !(&sync2);
  assign timeout   = (state == S_WAIT) && (tcnt == TW'(MOVE_TIMEOUT - 1));
  assign hit       = empty_mask[scan_idx];
  assign busy      = !((state == S_IDLE) || (state == S_WON) || (state == S_LOST));
  assign spawn_idx = scan_idx;

  // Fixed priority among simultaneous presses: up > down > left > right
  always_comb begin
    press_dir = 2'd3;
    if (!sync2[3])      press_dir = 2'd0;
    else if (!sync2[2]) press_dir = 2'd1;
    else if (!sync2[1]) press_dir = 2'd2;
  end

  // Next-state and single-cycle pulse outputs
  always_comb begin
    state_nx    = state;
    move_start  = 1'b0;
    spawn_valid = 1'b0;
    case (state)
      S_INIT0:  state_nx = S_SPAWN;
      S_INIT1:  state_nx = S_SPAWN;
      S_IDLE:   if (accept) state_nx = S_ISSUE;
      S_ISSUE: begin
        move_start = 1'b1;
        state_nx   = S_WAIT;
      end
      S_WAIT: begin
        if (move_done)    state_nx = board_changed ? S_SPAWN : S_IDLE;
        else if (timeout) state_nx = S_IDLE;
      end
      S_SPAWN: begin
        if (hit) begin
          spawn_valid = 1'b1;
          state_nx    = S_SETTLE;
        end else if ((empty_mask == '0) || (scan_cnt == 4'hF)) begin
          state_nx = S_CHECK;
        end
      end
      S_SETTLE: state_nx = init_phase ? S_INIT1 : S_CHECK;
      S_CHECK: begin
        if (check_win)       state_nx = S_WON;
        else if (check_over) state_nx = S_LOST;
        else                 state_nx = S_IDLE;
      end
      S_WON:    state_nx = S_WON;
      S_LOST:   state_nx = S_LOST;
      default:  state_nx = S_INIT0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT0;
    else      state <= state_nx;
  end

  // Free-running x^11+x^9+1 LFSR for tile placement
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= {lfsr[9:0], lfsr[10] ^ lfsr[8]};
  end

  // Button synchronisers and the re-arm flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
      armed <= 1'b1;
    end else begin
      sync1 <= {up, down, left, right};
      sync2 <= sync1;
      if (accept)      armed <= 1'b0;
      else if (&sync2) armed <= 1'b1;
    end
  end

  // Direction latch and game status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      move_dir   <= '0;
      game_state <= '0;
    end else begin
      if (accept) begin
        move_dir   <= press_dir;
        game_state <= 2'd0;
      end else if (timeout && !move_done) begin
        game_state <= 2'd3;
      end else if (state == S_CHECK) begin
        if (check_win)       game_state <= 2'd1;
        else if (check_over) game_state <= 2'd2;
      end
    end
  end

  // Spawn scan: seeded from the LFSR on entry, holds on the found cell
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_idx  <= '0;
      scan_cnt  <= '0;
      spawn_val <= '0;
    end else if ((state_nx == S_SPAWN) && (state != S_SPAWN)) begin
      scan_idx  <= lfsr[3:0];
      scan_cnt  <= '0;
      spawn_val <= (lfsr[10:8] == 3'b000) ? 12'd4 : 12'd2;
    end else if ((state == S_SPAWN) && !hit) begin
      scan_idx <= scan_idx + 4'd1;
      scan_cnt <= scan_cnt + 4'd1;
    end
  end

  // Move timeout counter and opening-tile phase flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt       <= '0;
      init_phase <= 1'b1;
    end else begin
      if (state == S_ISSUE)     tcnt <= '0;
      else if (state == S_WAIT) tcnt <= tcnt + TW'(1);
      if ((state == S_SETTLE) || (state == S_CHECK)) init_phase <= 1'b0;
    end
  end

endmodule
